// File: rtl/stream_parity_checker.sv
// Frame-level parity checker: XOR-accumulates DATA_W-bit words until the last word,
// checks the result against the parity bit and mode, and counts failed frames.
module stream_parity_checker #(
    parameter int DATA_W    = 4,
    parameter int MAX_WORDS = 16,
    parameter int ERR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    input  logic              mode,
    output logic              result_valid,
    output logic              result,
    output logic              overflow,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    state_t           state, state_nx;
    logic             acc, acc_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             mode_q, mode_nx;
    logic             result_nx, overflow_nx;
    logic             take;

    // Handshake: a word moves only when in_valid & in_ready in the same cycle; the source
    // must hold its word stable until then, and in_ready is low only during REPORT.
    assign in_ready     = (state != REPORT);
    assign result_valid = (state == REPORT);
    assign busy         = (state == ACCUM);
    assign take         = in_valid & in_ready;

    always_comb begin
        state_nx    = state;
        acc_nx      = acc;
        cnt_nx      = cnt;
        mode_nx     = mode_q;
        result_nx   = result;
        overflow_nx = overflow;
        case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    // A first word restarts the frame from zero and takes mode from the bus.
                    acc_nx  = ((state == IDLE) ? 1'b0 : acc) ^ (^in_data) ^ (in_last & in_par);
                    cnt_nx  = ((state == IDLE) ? '0 : cnt) + CNT_W'(1);
                    mode_nx = (state == IDLE) ? mode : mode_q;
                    if (in_last) begin
                        state_nx    = REPORT;
                        overflow_nx = 1'b0;
                        result_nx   = (acc_nx == mode_nx);
                    end else if (cnt_nx == CNT_MAX) begin
                        state_nx    = REPORT;
                        overflow_nx = 1'b1;
                        result_nx   = 1'b0;
                    end else begin
                        state_nx = ACCUM;
                    end
                end
            end
            REPORT: begin
                state_nx = IDLE;
                acc_nx   = 1'b0;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= 1'b0;
            cnt       <= '0;
            mode_q    <= 1'b0;
            result    <= 1'b0;
            overflow  <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            mode_q   <= mode_nx;
            result   <= result_nx;
            overflow <= overflow_nx;
            // Counter saturates so a long run of bad frames never wraps back to a small value.
            if (state == REPORT && !result && err_count != '1)
                err_count <= err_count + ERR_W'(1);
        end
    end

endmodule

// File: tb/tb_stream_parity_checker.sv
// Bench for stream_parity_checker: a default instance plus a MAX_WORDS=1 / ERR_W=2
// instance sharing the same stimulus, with a scoreboard on the default instance.
module tb_stream_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_last, in_par, mode;

    logic       in_ready, result_valid, result, overflow, busy;
    logic [7:0] err_count;
    logic       in_ready2, result_valid2, result2, overflow2, busy2;
    logic [1:0] err_count2;

    int checks   = 0;
    int failures = 0;
    int exp_err;

    logic [1:0] exp_q[$];

    typedef struct {
        logic [3:0] d;
        logic       p;
        logic       m;
        logic       exp;
    } vec_t;
    vec_t vecs[64];

    stream_parity_checker dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .mode(mode),
        .result_valid(result_valid), .result(result), .overflow(overflow),
        .err_count(err_count), .busy(busy)
    );

    stream_parity_checker #(.DATA_W(4), .MAX_WORDS(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .in_par(in_par), .mode(mode),
        .result_valid(result_valid2), .result(result2), .overflow(overflow2),
        .err_count(err_count2), .busy(busy2)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // driver: offers one word and returns at the posedge that transfers it
    task automatic send(input logic [3:0] d, input logic l, input logic p, input logic m);
        int tries;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_par   = p;
        mode     = m;
        tries = 0;
        while (!in_ready && tries < 8) begin
            @(negedge clk);
            tries++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%0b expected 1", in_ready);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // scoreboard on the default instance
    always @(negedge clk) begin
        if (!rst && result_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: result=%0b overflow=%0b", result, overflow);
            end else begin
                chk("result_overflow", {30'd0, result, overflow}, {30'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_par = 1'b0; mode = 1'b0;

        for (int i = 0; i < 64; i++) begin
            vecs[i].d   = 4'(i);
            vecs[i].p   = i[4];
            vecs[i].m   = i[5];
            vecs[i].exp = ((($countones(vecs[i].d) + int'(vecs[i].p)) % 2) == int'(vecs[i].m));
        end

        // reset state
        do_reset();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_busy", busy, 0);

        // exhaustive single-word frames, back to back
        exp_err = 0;
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back({vecs[i].exp, 1'b0});
            if (!vecs[i].exp) exp_err++;
            send(vecs[i].d, 1'b1, vecs[i].p, vecs[i].m);
        end
        idle();
        @(negedge clk);
        chk("single_err_count", err_count, exp_err);

        // multi-word even frame: 6 ones, then the same frame with a wrong parity bit
        exp_q.push_back(2'b10);
        send(4'b0011, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("multi_busy", busy, 1);
        send(4'b0101, 1'b0, 1'b0, 1'b0);
        send(4'b0001, 1'b1, 1'b1, 1'b0);
        idle();
        @(negedge clk);
        chk("multi_ok_err", err_count, exp_err);
        exp_q.push_back(2'b00);
        send(4'b0011, 1'b0, 1'b0, 1'b0);
        send(4'b0101, 1'b0, 1'b0, 1'b0);
        send(4'b0001, 1'b1, 1'b0, 1'b0);
        idle();
        @(negedge clk);
        exp_err++;
        chk("multi_bad_err", err_count, exp_err);

        // overflow: 16 words with no last marker
        exp_q.push_back(2'b01);
        for (int i = 0; i < 16; i++) send(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
        idle();
        chk("ovf_in_ready", in_ready, 0);
        chk("ovf_result_valid", result_valid, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_result", result, 0);
        @(negedge clk);
        chk("ovf_idle_busy", busy, 0);
        chk("ovf_idle_ready", in_ready, 1);
        chk("ovf_overflow_hold", overflow, 1);
        exp_err++;
        chk("ovf_err", err_count, exp_err);

        // gaps, mode latched on first word, word offered during REPORT
        exp_q.push_back(2'b10);
        send(4'b0110, 1'b0, 1'b0, 1'b1);
        idle();
        repeat (3) @(negedge clk);
        chk("gap_busy", busy, 1);
        send(4'b0100, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        exp_q.push_back(2'b10);
        in_valid = 1'b1; in_data = 4'b1000; in_last = 1'b1; in_par = 1'b1; mode = 1'b0;
        chk("report_in_ready", in_ready, 0);
        chk("report_strobe", result_valid, 1);
        @(negedge clk);
        chk("after_report_ready", in_ready, 1);
        chk("after_report_busy", busy, 0);
        @(posedge clk);
        idle();
        chk("report_word_strobe", result_valid, 1);
        @(negedge clk);
        chk("gap_err", err_count, exp_err);

        // saturation on the ERR_W=2 instance
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(2'b00);
            send(4'b0000, 1'b1, 1'b1, 1'b0);
            idle();
            @(negedge clk);
            chk("sat_err2", err_count2, (i > 3) ? 3 : i);
            chk("sat_err1", err_count, i);
        end

        // MAX_WORDS=1: one non-last word overflows the small instance
        send(4'b0001, 1'b0, 1'b0, 1'b0);
        idle();
        chk("mw1_strobe", result_valid2, 1);
        chk("mw1_overflow", overflow2, 1);
        chk("mw1_result", result2, 0);
        chk("mw1_in_ready", in_ready2, 0);
        chk("mw1_big_busy", busy, 1);

        // reset mid-frame
        do_reset();
        send(4'b1111, 1'b0, 1'b0, 1'b0);
        send(4'b0011, 1'b0, 1'b0, 1'b0);
        send(4'b0101, 1'b0, 1'b0, 1'b0);
        err_count_pre: chk("pre_rst_busy", busy, 1);
        do_reset();
        chk("midrst_err", err_count, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        chk("midrst_no_strobe", result_valid, 0);
        exp_q.push_back(2'b10);
        send(4'b0111, 1'b0, 1'b0, 1'b0);
        send(4'b0001, 1'b0, 1'b0, 1'b0);
        send(4'b0000, 1'b0, 1'b0, 1'b0);
        send(4'b1111, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(2'b10);
        send(4'b0111, 1'b0, 1'b0, 1'b1);
        send(4'b0000, 1'b1, 1'b0, 1'b1);
        idle();
        repeat (2) @(negedge clk);
        chk("post_rst_err", err_count, 0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
